// File: rtl/game_pkg.sv
// game_pkg: shared FSM states, level encodings and LFSR constants for the round controller
package game_pkg;
    typedef enum logic [2:0] {IDLE, GEN, SHOW_ON, SHOW_OFF, INPUT, JUDGE, DONE} state_t;
    localparam logic [1:0] LVL_NONE = 2'd0;
    localparam logic [1:0] LVL_1 = 2'd1;
    localparam logic [1:0] LVL_2 = 2'd2;
    localparam logic [1:0] LVL_3 = 2'd3;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_POLY = 16'hB400;
endpackage

// File: rtl/game_lfsr.sv
// game_lfsr: free-running 16-bit Galois LFSR feeding pattern generation
//   clk_1 - system clock
//   rst   - asynchronous active-low reset, loads LFSR_SEED
//   q     - current LFSR state
module game_lfsr
    import game_pkg::*;
(
    input  logic        clk_1,
    input  logic        rst,
    output logic [15:0] q
);
    always_ff @(posedge clk_1 or negedge rst)
        if (!rst) q <= LFSR_SEED;
        else q <= q[0] ? (q >> 1) ^ LFSR_POLY : q >> 1;
endmodule

// File: rtl/game_round_ctrl.sv
// game_round_ctrl: memory-game round controller (show pattern, collect presses, judge, score)
//   clk_1, rst        - clock, asynchronous active-low reset
//   start, level      - start a game at difficulty 1..3 (0 ignored)
//   tick              - playback/timeout strobe
//   btn               - single-cycle button press pulses
//   led               - pattern playback, button echo, all-ones when game over
//   round_cnt, score  - rounds completed, saturating score
//   busy              - game in progress
//   round_done/_win   - one-cycle judgement pulse and outcome
//   game_end          - set after the last round until the next start
//   Define GAME_TIMEOUT_EN to judge a round lost after TIMEOUT_TICKS idle ticks in INPUT.
module game_round_ctrl
    import game_pkg::*;
#(
    parameter int N_BTN = 8,
    parameter int MAX_LEN = 16,
    parameter int N_ROUNDS = 10,
    parameter int SCORE_STEP = 10,
    parameter int TIMEOUT_TICKS = 50
) (
    input  logic                          clk_1,
    input  logic                          rst,
    input  logic                          start,
    input  logic [1:0]                    level,
    input  logic                          tick,
    input  logic [N_BTN-1:0]              btn,
    output logic [N_BTN-1:0]              led,
    output logic [$clog2(N_ROUNDS+1)-1:0] round_cnt,
    output logic [15:0]                   score,
    output logic                          busy,
    output logic                          round_done,
    output logic                          round_win,
    output logic                          game_end
);
    localparam int SW = N_BTN > 1 ? $clog2(N_BTN) : 1;
    localparam int IW = $clog2(MAX_LEN);
    localparam int RW = $clog2(N_ROUNDS + 1);

    state_t state, nxt;
    logic [SW-1:0] pattern [MAX_LEN];
    logic [IW-1:0] idx, last;
    logic [15:0] lfsr;
    logic [SW-1:0] sym;
    logic [N_BTN-1:0] cur_hot;
    logic [16:0] sum;
    logic win, go, hit, miss, timeout;

    game_lfsr u_lfsr (.clk_1(clk_1), .rst(rst), .q(lfsr));

    assign sym = SW'(lfsr % N_BTN);
    assign cur_hot = N_BTN'(1) << pattern[idx];
    assign go = start && level != LVL_NONE && (state == IDLE || state == DONE);
    // exact equality with the expected one-hot rejects multi-button presses too
    assign hit = btn == cur_hot;
    assign miss = btn != '0 && !hit;
    assign sum = {1'b0, score} + 17'(SCORE_STEP);

`ifdef GAME_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_TICKS + 1);
    logic [TW-1:0] tcnt;
    always_ff @(posedge clk_1 or negedge rst)
        if (!rst) tcnt <= '0;
        else tcnt <= (state != INPUT || btn != '0) ? '0 : tcnt + TW'(tick);
    assign timeout = state == INPUT && btn == '0 && tick && tcnt == TW'(TIMEOUT_TICKS - 1);
`else
    logic unused_timeout;
    assign unused_timeout = |TIMEOUT_TICKS;
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk_1 or negedge rst)
        if (!rst) state <= IDLE;
        else state <= nxt;

    always_comb begin
        nxt = state;
        led = '0;
        busy = state != IDLE && state != DONE;
        round_done = state == JUDGE;
        round_win = state == JUDGE && win;
        game_end = state == DONE;
        case (state)
            IDLE, DONE: nxt = go ? GEN : state;
            GEN:        nxt = idx == last ? SHOW_ON : GEN;
            SHOW_ON:    nxt = tick ? SHOW_OFF : SHOW_ON;
            SHOW_OFF:   nxt = !tick ? SHOW_OFF : idx == last ? INPUT : SHOW_ON;
            INPUT:      nxt = (miss || timeout || (hit && idx == last)) ? JUDGE : INPUT;
            JUDGE:      nxt = round_cnt == RW'(N_ROUNDS - 1) ? DONE : GEN;
            default:    nxt = IDLE;
        endcase
        led = state == SHOW_ON ? cur_hot : state == INPUT ? btn : state == DONE ? '1 : '0;
    end

    always_ff @(posedge clk_1 or negedge rst)
        if (!rst) begin
            idx <= '0;
            last <= '0;
            win <= 1'b0;
            round_cnt <= '0;
            score <= '0;
        end else begin
            if (go) begin
                idx <= '0;
                round_cnt <= '0;
                score <= '0;
                last <= level == LVL_1 ? IW'(MAX_LEN / 2 - 1) :
                        level == LVL_2 ? IW'(3 * MAX_LEN / 4 - 1) : IW'(MAX_LEN - 1);
            end
            if (state == GEN || (state == SHOW_OFF && tick) || (state == INPUT && hit))
                idx <= idx == last ? '0 : idx + 1'b1;
            // refreshed every INPUT cycle so the value entering JUDGE is the verdict
            if (state == INPUT) win <= hit && idx == last;
            if (state == JUDGE) begin
                idx <= '0;
                round_cnt <= round_cnt + 1'b1;
                score <= !win ? score : sum[16] ? 16'hFFFF : sum[15:0];
            end
        end

    always_ff @(posedge clk_1)
        if (state == GEN) pattern[idx] <= sym;
endmodule

// File: tb/tb_game_round_ctrl.sv
// tb_game_round_ctrl: scoreboard bench for game_round_ctrl
module tb_game_round_ctrl;
    localparam int N_BTN = 8;
    localparam int MAX_LEN = 16;

    logic clk_1 = 0, rst = 1, start = 0, tick = 0;
    logic [1:0] level = 0;
    logic [N_BTN-1:0] btn = 0;
    logic [N_BTN-1:0] led;
    logic [3:0] round_cnt;
    logic [15:0] score;
    logic busy, round_done, round_win, game_end;

    game_round_ctrl dut (
        .clk_1(clk_1), .rst(rst), .start(start), .level(level), .tick(tick), .btn(btn),
        .led(led), .round_cnt(round_cnt), .score(score), .busy(busy),
        .round_done(round_done), .round_win(round_win), .game_end(game_end)
    );

    always #5 clk_1 = ~clk_1;

    typedef struct {logic win; int cnt; int score;} exp_t;
    exp_t q[$];
    exp_t pe;
    logic pend = 0;
    int vecs = 0, errs = 0;
    int exp_cnt = 0, exp_score = 0;
    logic [N_BTN-1:0] pat [MAX_LEN];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk_1) begin
        if (pend) begin
            chk("round_cnt after judge", 32'(round_cnt), 32'(pe.cnt));
            chk("score after judge", 32'(score), 32'(pe.score));
            pend = 0;
        end
        if (rst && round_done) begin
            if (q.size() == 0) begin
                vecs++;
                errs++;
                $display("FAIL unexpected round_done: got win=%0d expected none", round_win);
            end else begin
                pe = q.pop_front();
                chk("round_win", 32'(round_win), 32'(pe.win));
                pend = 1;
            end
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) @(negedge clk_1);
    endtask

    task automatic pulse_tick;
        tick = 1;
        cyc(1);
        tick = 0;
    endtask

    task automatic press(input logic [N_BTN-1:0] b);
        btn = b;
        cyc(1);
        btn = 0;
    endtask

    task automatic wait_show(output logic ok);
        int to = 0;
        while (led == 0 && to < 200) begin
            cyc(1);
            to++;
        end
        ok = to < 200;
        if (!ok) begin
            vecs++;
            errs++;
            $display("FAIL show start: got no lit LED within 200 cycles expected playback");
        end
    endtask

    task automatic show(input int len);
        int w = 0, dark = 0;
        logic ok;
        wait_show(ok);
        for (int k = 0; k < len; k++) begin
            pat[k] = led;
            if ($onehot(led)) w++;
            pulse_tick;
            cyc(1);
            if (led != 0) dark++;
            pulse_tick;
        end
        chk("led dark after last symbol", 32'(led), 0);
        chk("one-hot show windows", 32'(w), 32'(len));
        chk("dark gaps", 32'(dark), 0);
    endtask

    task automatic win_round(input int len);
        exp_cnt++;
        exp_score += 10;
        q.push_back('{win: 1'b1, cnt: exp_cnt, score: exp_score});
        for (int k = 0; k < len; k++) press(pat[k]);
        cyc(2);
    endtask

    task automatic lose_round(input int kbad, input logic [N_BTN-1:0] bad);
        exp_cnt++;
        q.push_back('{win: 1'b0, cnt: exp_cnt, score: exp_score});
        for (int k = 0; k < kbad; k++) press(pat[k]);
        press(bad);
        chk("round_done next cycle", 32'(round_done), 1);
        cyc(2);
    endtask

    function automatic logic [N_BTN-1:0] rot(input logic [N_BTN-1:0] v);
        return {v[N_BTN-2:0], v[N_BTN-1]};
    endfunction

    initial begin
        logic ok;
        #1 rst = 0;
        cyc(2);
        chk("reset outputs", {led, round_cnt, score, busy, round_done, round_win, game_end}, 0);
        rst = 1;
        cyc(2);
        level = 0;
        start = 1;
        cyc(1);
        start = 0;
        cyc(2);
        chk("level0 start ignored", 32'(busy), 0);
        level = 1;
        start = 1;
        cyc(1);
        start = 0;
        chk("busy after start", 32'(busy), 1);
        for (int r = 0; r < 10; r++) begin
            show(8);
            if (r == 0) begin
                level = 3;
                start = 1;
                cyc(1);
                start = 0;
                chk("start in INPUT ignored", 32'(busy), 1);
                win_round(8);
            end else if (r == 1) lose_round(3, rot(pat[3]));
            else if (r == 2) lose_round(0, pat[0] | rot(pat[0]));
            else if (r == 5) lose_round(5, rot(pat[5]));
            else win_round(8);
        end
        chk("game_end", 32'(game_end), 1);
        chk("led all ones", 32'(led), 32'hFF);
        chk("busy in DONE", 32'(busy), 0);
        chk("final rounds", 32'(round_cnt), 10);
        chk("final score", 32'(score), 70);
        pulse_tick;
        chk("DONE holds", 32'(game_end), 1);
        exp_cnt = 0;
        exp_score = 0;
        level = 2;
        start = 1;
        cyc(1);
        start = 0;
        chk("restart busy", 32'(busy), 1);
        chk("restart game_end", 32'(game_end), 0);
        chk("restart cleared", {round_cnt, score}, 0);
        for (int r = 0; r < 3; r++) begin
            show(12);
            win_round(12);
        end
        wait_show(ok);
        #2 rst = 0;
        #1 chk("mid-game reset outputs", {led, round_cnt, score, busy, round_done, round_win, game_end}, 0);
        cyc(1);
        rst = 1;
        cyc(2);
        chk("idle after reset", {busy, game_end}, 0);
        exp_cnt = 0;
        exp_score = 0;
        level = 3;
        start = 1;
        cyc(1);
        start = 0;
        show(16);
`ifdef GAME_TIMEOUT_EN
        exp_cnt = 1;
        q.push_back('{win: 1'b0, cnt: 1, score: 0});
        repeat (49) begin
            pulse_tick;
            cyc(1);
        end
        chk("no judge before limit", 32'(round_done), 0);
        pulse_tick;
        chk("timeout judge", 32'(round_done), 1);
        cyc(2);
`else
        repeat (1000) begin
            pulse_tick;
            cyc(1);
        end
        chk("still waiting", {busy, round_cnt}, 32'h10);
        win_round(16);
`endif
        cyc(4);
        chk("scoreboard drained", 32'(q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish by 1ms expected completion");
        $fatal(1);
    end
endmodule
